// File: rtl/jzjpcc_memory_backend_dp_if.sv
// Fetch, memory-stage and I/O signals between the jzjpcc pipeline and its dual-port memory backend.
interface jzjpcc_memory_backend_dp_if #(
    parameter int unsigned PC_MAX_B = 13,
    parameter int unsigned NUM_IO   = 4
);
    logic [PC_MAX_B:2]       instructionAddressToLatch;
    logic                    fetch_stall;
    logic [31:0]             instruction_fetch;
    logic                    mem_enable;
    logic                    mem_write;
    logic [2:0]              mem_funct3;
    logic [31:0]             mem_address;
    logic [31:0]             mem_write_data;
    logic [31:0]             mem_read_data;
    logic                    mem_misaligned;
    logic [NUM_IO*32-1:0]    io_in;
    logic [NUM_IO*32-1:0]    io_out;

    modport master (
        output instructionAddressToLatch, fetch_stall,
        output mem_enable, mem_write, mem_funct3, mem_address, mem_write_data,
        output io_in,
        input  instruction_fetch, mem_read_data, mem_misaligned, io_out
    );

    modport slave (
        input  instructionAddressToLatch, fetch_stall,
        input  mem_enable, mem_write, mem_funct3, mem_address, mem_write_data,
        input  io_in,
        output instruction_fetch, mem_read_data, mem_misaligned, io_out
    );
endinterface

// File: rtl/jzjpcc_memory_backend_dp.sv
// Dual-port SRAM backend: port A serves instruction fetch, port B serves RV32I loads/stores
// plus a small bank of memory-mapped I/O registers.
module jzjpcc_memory_backend_dp #(
    parameter string       INITIAL_MEM_CONTENTS = "none",
    parameter int unsigned RAM_A_WIDTH          = 12,
    parameter int unsigned PC_MAX_B             = 13,
    parameter int unsigned NUM_IO               = 4,
    parameter logic [31:0] IO_BASE              = 32'hFFFFFFE0
) (
    input logic clock,
    input logic reset,
    jzjpcc_memory_backend_dp_if.slave bus
);
    localparam int unsigned ram_words = 2 ** RAM_A_WIDTH;
    localparam int unsigned io_idx_w  = (NUM_IO > 1) ? $clog2(NUM_IO) : 1;
    localparam logic [31:0] nop_be    = 32'h13000000;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    (* ram_init_file = INITIAL_MEM_CONTENTS *) logic [31:0] ram [ram_words];

    logic [31:0]             fetch_q;
    logic [31:0]             read_q;
    logic                    misaligned_q;
    logic [31:0]             io_q    [NUM_IO];
    logic [31:0]             io_in_q [NUM_IO];

    logic [1:0]              lane;
    logic [31:0]             io_off;
    logic                    is_io;
    logic                    is_ram;
    logic [io_idx_w-1:0]     io_idx;
    logic [RAM_A_WIDTH-1:0]  widx;
    logic                    legal;
    logic                    aligned;
    logic                    bad;
    logic [3:0]              mask;
    logic [31:0]             wdata;
    logic                    store_ok;
    logic                    ram_we;
    logic                    io_we;
    logic [31:0]             src;
    logic [31:0]             sh;
    logic [31:0]             ld;

    // Port B request decode: target, alignment, byte mask and lane-replicated store data.
    always_comb begin
        lane     = bus.mem_address[1:0];
        io_off   = bus.mem_address - IO_BASE;
        is_io    = io_off < 32'(4 * NUM_IO);
        io_idx   = io_off[2 +: io_idx_w];
        is_ram   = (bus.mem_address >> (RAM_A_WIDTH + 2)) == 32'd0;
        widx     = bus.mem_address[RAM_A_WIDTH+1:2];
        legal    = 1'b1;
        aligned  = 1'b1;
        mask     = 4'b0000;
        wdata    = bus.mem_write_data;
        case (bus.mem_funct3)
            3'b000, 3'b100: begin
                mask  = 4'b0001 << lane;
                wdata = {4{bus.mem_write_data[7:0]}};
            end
            3'b001, 3'b101: begin
                aligned = ~lane[0];
                mask    = 4'b0011 << lane;
                wdata   = {2{bus.mem_write_data[15:0]}};
            end
            3'b010: begin
                aligned = lane == 2'd0;
                mask    = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
        bad      = ~legal | ~aligned;
        store_ok = bus.mem_enable & bus.mem_write & ~bad & ~reset;
        ram_we   = store_ok & is_ram & ~is_io;
        io_we    = store_ok & is_io;
    end

    // Load path: pick the source word, shift the addressed lane down, then extend.
    always_comb begin
        src = 32'd0;
        if (is_io)
            src = io_in_q[io_idx];
        else if (is_ram)
            src = ram[widx];
        sh = src >> {lane, 3'b000};
        case (bus.mem_funct3)
            3'b000:  ld = {{24{sh[7]}}, sh[7:0]};
            3'b100:  ld = {24'd0, sh[7:0]};
            3'b001:  ld = {{16{sh[15]}}, sh[15:0]};
            3'b101:  ld = {16'd0, sh[15:0]};
            3'b010:  ld = src;
            default: ld = 32'd0;
        endcase
        if (bad)
            ld = 32'd0;
    end

    // Port B SRAM write; NBA keeps the same-edge port A read seeing the old word.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && mask[b])
                ram[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            fetch_q <= nop_be;
        else if (!bus.fetch_stall)
            fetch_q <= bswap(ram[RAM_A_WIDTH'(bus.instructionAddressToLatch)]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_q       <= 32'd0;
            misaligned_q <= 1'b0;
        end else if (bus.mem_enable) begin
            misaligned_q <= bad;
            if (!bus.mem_write)
                read_q <= ld;
        end
    end

    // I/O output registers take the same byte mask as RAM stores; inputs are sampled every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_IO; i++) begin
                io_q[i]    <= 32'd0;
                io_in_q[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < NUM_IO; i++)
                io_in_q[i] <= bus.io_in[32*i +: 32];
            for (int b = 0; b < 4; b++) begin
                if (io_we && mask[b])
                    io_q[io_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    for (genvar i = 0; i < NUM_IO; i++) begin : g_io_out
        assign bus.io_out[32*i +: 32] = io_q[i];
    end

    assign bus.instruction_fetch = fetch_q;
    assign bus.mem_read_data     = read_q;
    assign bus.mem_misaligned    = misaligned_q;
endmodule
